// File: rtl/regfile_dump_pkg.sv
// +----------------------------------------------------------------------+
// | regfile_dump_pkg: shared widths and FSM encoding for regfile_dump    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package regfile_dump_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HALT   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SEND   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_HALT   = HALT,
    ST_SETTLE = SETTLE,
    ST_SEND   = SEND,
    ST_DONE   = DONE
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_dump_if.sv
// +----------------------------------------------------------------------+
// | regfile_dump_if: core control, register-file port A and sample stream |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface regfile_dump_if
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              Start;
  logic              Halt;
  logic [ADDR_W-1:0] Rs;
  logic [DATA_W-1:0] busA;
  logic              OutValid;
  logic              OutReady;
  logic [ADDR_W-1:0] OutIndex;
  logic [DATA_W-1:0] OutData;
  logic              Busy;
  logic              Done;

  modport master (
    input  Start, busA, OutReady,
    output Halt, Rs, OutValid, OutIndex, OutData, Busy, Done
  );

  modport slave (
    output Start, busA, OutReady,
    input  Halt, Rs, OutValid, OutIndex, OutData, Busy, Done
  );

endinterface

`default_nettype wire

// File: rtl/regfile_dump.sv
// +----------------------------------------------------------------------+
// | regfile_dump: halts the core and streams register contents out       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int FIRST_REG     = 0,
  parameter int LAST_REG      = 31,
  parameter int SETTLE_CYCLES = 1
) (
  input  wire logic      Clk,
  input  wire logic      Reset_n,
  regfile_dump_if.master bus
);

  localparam int                CNT_W     = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(LAST_REG);

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   idx_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                halt_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   out_idx_q;
  logic [DATA_W-1:0]   out_data_q;

  assign idx_d = idx_q + 1'b1;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      halt_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.Start) begin
            state_q <= ST_HALT;
            halt_q  <= 1'b1;
            busy_q  <= 1'b1;
            idx_q   <= IDX_FIRST;
          end
        end
        // Extra cycle lets the core's pending negedge write be blocked by Halt.
        ST_HALT: begin
          state_q <= ST_SETTLE;
          cnt_q   <= '0;
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_q    <= ST_SEND;
            out_data_q <= bus.busA;
            out_idx_q  <= idx_q;
            valid_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SEND: begin
          if (bus.OutReady) begin
            valid_q <= 1'b0;
            if (idx_q >= IDX_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              cnt_q   <= '0;
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          halt_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Halt     = halt_q;
  assign bus.Rs       = idx_q;
  assign bus.OutValid = valid_q;
  assign bus.OutIndex = out_idx_q;
  assign bus.OutData  = out_data_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
// +----------------------------------------------------------------------+
// | tb_regfile_dump: scenario table plus scoreboard for regfile_dump     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_regfile_dump;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  start_r = 3'b000;
  logic [2:0]  ready_r = 3'b111;
  logic [31:0] regs [32];

  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus_a ();
  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus_b ();
  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus_c ();

  regfile_dump #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31), .SETTLE_CYCLES(1))
    dut_a (.Clk(clk), .Reset_n(rst_n), .bus(bus_a));
  regfile_dump #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(5), .LAST_REG(5), .SETTLE_CYCLES(1))
    dut_b (.Clk(clk), .Reset_n(rst_n), .bus(bus_b));
  regfile_dump #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31), .SETTLE_CYCLES(3))
    dut_c (.Clk(clk), .Reset_n(rst_n), .bus(bus_c));

  assign bus_a.Start = start_r[0];
  assign bus_b.Start = start_r[1];
  assign bus_c.Start = start_r[2];
  assign bus_a.OutReady = ready_r[0];
  assign bus_b.OutReady = ready_r[1];
  assign bus_c.OutReady = ready_r[2];
  assign bus_a.busA = regs[bus_a.Rs];
  assign bus_b.busA = regs[bus_b.Rs];
  assign bus_c.busA = regs[bus_c.Rs];

  logic [2:0]  vld, halt, busy, done;
  logic [4:0]  idx_o [3];
  logic [4:0]  rs_o  [3];
  logic [31:0] dat_o [3];
  assign vld  = {bus_c.OutValid, bus_b.OutValid, bus_a.OutValid};
  assign halt = {bus_c.Halt, bus_b.Halt, bus_a.Halt};
  assign busy = {bus_c.Busy, bus_b.Busy, bus_a.Busy};
  assign done = {bus_c.Done, bus_b.Done, bus_a.Done};
  assign idx_o[0] = bus_a.OutIndex;
  assign idx_o[1] = bus_b.OutIndex;
  assign idx_o[2] = bus_c.OutIndex;
  assign rs_o[0]  = bus_a.Rs;
  assign rs_o[1]  = bus_b.Rs;
  assign rs_o[2]  = bus_c.Rs;
  assign dat_o[0] = bus_a.OutData;
  assign dat_o[1] = bus_b.OutData;
  assign dat_o[2] = bus_c.OutData;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } smp_t;
  smp_t sbq[$];

  typedef struct {
    int          k;
    int          stall_at;
    int          stall_len;
    int          exp_cnt;
    int          exp_lat;
    int          exp_gap;
    logic [31:0] r5;
  } vec_t;
  vec_t tbl [4];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic preload(input logic [31:0] r5);
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + i;
    regs[5] = r5;
  endtask

  task automatic push_exp(input int k);
    int   first;
    int   last;
    smp_t s;
    first = (k == 1) ? 5 : 0;
    last  = (k == 1) ? 5 : 31;
    for (int i = first; i <= last; i++) begin
      s.idx  = 5'(i);
      s.data = regs[i];
      sbq.push_back(s);
    end
  endtask

  task automatic run_dump(input int k, input int stall_at, input int stall_len,
                          input int exp_cnt, input int exp_lat, input int exp_gap);
    int          t0, first_vld, last_acc, acc_cnt, stalled, done_cyc, done_cnt, halt_bad;
    bit          fin;
    logic [31:0] held;
    push_exp(k);
    @(posedge clk); #1;
    start_r[k] = 1'b1;
    ready_r[k] = 1'b1;
    t0 = cyc;
    first_vld = -1; last_acc = -1; acc_cnt = 0; stalled = 0;
    done_cyc = -1; done_cnt = 0; halt_bad = 0; fin = 1'b0; held = '0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      @(negedge clk);
      if (vld[k] && first_vld < 0) first_vld = cyc;
      if (cyc > t0 && done_cyc < 0 && (!halt[k] || !busy[k])) halt_bad++;
      if (done[k]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end else if (done_cyc >= 0) begin
        fin = 1'b1;
        check("halt_after_done", {63'd0, halt[k]}, 64'd0);
        check("busy_after_done", {63'd0, busy[k]}, 64'd0);
      end
      if (vld[k] && ready_r[k]) begin
        acc_cnt++;
        if (last_acc >= 0 && int'(idx_o[k]) != stall_at)
          check("sample_gap", 64'(cyc - last_acc), 64'(exp_gap));
        last_acc = cyc;
      end
      @(posedge clk); #1;
      start_r[k] = 1'b0;
      if (vld[k] && int'(idx_o[k]) == stall_at && stalled < stall_len) begin
        if (stalled == 0) held = dat_o[k];
        else check("stall_data", {32'd0, dat_o[k]}, {32'd0, held});
        ready_r[k] = 1'b0;
        stalled++;
      end else begin
        ready_r[k] = 1'b1;
      end
    end
    check("dump_finished", {63'd0, fin}, 64'd1);
    check("first_latency", 64'(first_vld - t0), 64'(exp_lat));
    check("sample_count", 64'(acc_cnt), 64'(exp_cnt));
    check("done_after_last", 64'(done_cyc - last_acc), 64'd1);
    check("done_width", 64'(done_cnt), 64'd1);
    check("halt_busy_held", 64'(halt_bad), 64'd0);
    check("sb_drained", 64'(sbq.size()), 64'd0);
    if (stall_at >= 0) check("stall_cycles", 64'(stalled), 64'(stall_len));
    sbq.delete();
  endtask

  initial begin
    bit found;
    bit done_seen;
    smp_t s;

    tbl[0] = '{0, -1, 0, 32, 3, 2, 32'hA000_0005};
    tbl[1] = '{0,  7, 5, 32, 3, 2, 32'hA000_0005};
    tbl[2] = '{1, -1, 0,  1, 3, 2, 32'hDEAD_BEEF};
    tbl[3] = '{2, -1, 0, 32, 5, 4, 32'hA000_0005};

    preload(32'hA000_0005);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_busy",  {63'd0, busy[k]}, 64'd0);
      check("rst_halt",  {63'd0, halt[k]}, 64'd0);
      check("rst_valid", {63'd0, vld[k]},  64'd0);
      check("rst_done",  {63'd0, done[k]}, 64'd0);
      check("rst_rs",    {59'd0, rs_o[k]},  64'd0);
      check("rst_index", {59'd0, idx_o[k]}, 64'd0);
      check("rst_data",  {32'd0, dat_o[k]}, 64'd0);
    end

    // Scoreboard: every accepted sample is matched against the queue head.
    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (vld[k] && ready_r[k]) begin
            if (sbq.size() == 0) begin
              check("sb_unexpected", 64'd1, 64'd0);
            end else begin
              s = sbq.pop_front();
              check("sb_index", {59'd0, idx_o[k]}, {59'd0, s.idx});
              check("sb_data",  {32'd0, dat_o[k]}, {32'd0, s.data});
            end
          end
        end
      end
    join_none

    for (int v = 0; v < 4; v++) begin
      preload(tbl[v].r5);
      run_dump(tbl[v].k, tbl[v].stall_at, tbl[v].stall_len,
               tbl[v].exp_cnt, tbl[v].exp_lat, tbl[v].exp_gap);
      repeat (2) @(posedge clk);
    end

    // Reset while sample 10 is on the bus.
    preload(32'hA000_0005);
    push_exp(0);
    @(posedge clk); #1;
    start_r[0] = 1'b1;
    ready_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      if (vld[0] && idx_o[0] == 5'd10) found = 1'b1;
    end
    check("rst_reach_10", {63'd0, found}, 64'd1);
    rst_n = 1'b0;
    ready_r[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_r[0] = 1'b1;
    @(negedge clk);
    check("abort_busy",  {63'd0, busy[0]}, 64'd0);
    check("abort_halt",  {63'd0, halt[0]}, 64'd0);
    check("abort_valid", {63'd0, vld[0]},  64'd0);
    check("abort_index", {59'd0, idx_o[0]}, 64'd0);
    done_seen = done[0];
    repeat (6) begin
      @(negedge clk);
      if (done[0]) done_seen = 1'b1;
    end
    check("abort_no_done", {63'd0, done_seen}, 64'd0);
    check("abort_partial", 64'(sbq.size()), 64'd22);
    sbq.delete();
    run_dump(0, -1, 0, 32, 3, 2);

    // Start re-pulsed mid-dump while the core tries to overwrite R3.
    preload(32'hA000_0005);
    fork
      run_dump(0, -1, 0, 32, 3, 2);
      begin
        repeat (5) @(posedge clk);
        #1 start_r[0] = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (!halt[0]) regs[3] = 32'h5555_5555;
        end
        @(posedge clk); #1 start_r[0] = 1'b0;
      end
    join
    check("r3_protected", {32'd0, regs[3]}, {32'd0, 32'hA000_0003});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
